mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 194 +++++++++++++++++++
 tb/tb_mem_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Pipeline MEM stage: passes ALU results through and runs loads/stores as
// 1/2/4 little-endian byte accesses over a shared byte-wide RAM port.
`ifndef MEM_STAGE_DEFINES
`define MEM_STAGE_DEFINES
`define OpCodeLen 8
`define MEM_NOP   8'h00
`define EX_LB     8'h20
`define EX_LH     8'h21
`define EX_LW     8'h22
`define EX_LBU    8'h23
`define EX_LHU    8'h24
`define EX_SB     8'h25
`define EX_SH     8'h26
`define EX_SW     8'h27
`endif

module mem_stage (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [`OpCodeLen-1:0] aluop_i,
  input  logic [4:0]            rd_addr_i,
  input  logic                  rd_enable_i,
  input  logic [31:0]           data_i,
  input  logic [31:0]           mem_addr_i,
  input  logic                  mem_gnt,
  input  logic [7:0]            mem_din,
  output logic                  mem_req,
  output logic [31:0]           mem_a,
  output logic [7:0]            mem_dout,
  output logic                  mem_wr,
  output logic [4:0]            rd_addr_o,
  output logic                  rd_enable_o,
  output logic [31:0]           wb_data_o,
  output logic                  stall_req
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic logic is_load(input logic [`OpCodeLen-1:0] op);
    case (op)
      `EX_LB, `EX_LH, `EX_LW, `EX_LBU, `EX_LHU: is_load = 1'b1;
      default:                                  is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [`OpCodeLen-1:0] op);
    case (op)
      `EX_SB, `EX_SH, `EX_SW: is_store = 1'b1;
      default:                is_store = 1'b0;
    endcase
  endfunction

  // Index of the last byte of the access (N-1).
  function automatic logic [1:0] last_idx(input logic [`OpCodeLen-1:0] op);
    case (op)
      `EX_LB, `EX_LBU, `EX_SB: last_idx = 2'd0;
      `EX_LH, `EX_LHU, `EX_SH: last_idx = 2'd1;
      default:                 last_idx = 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [`OpCodeLen-1:0] op,
                                         input logic [31:0] b);
    case (op)
      `EX_LB:  extend = {{24{b[7]}}, b[7:0]};
      `EX_LH:  extend = {{16{b[15]}}, b[15:0]};
      `EX_LBU: extend = {24'd0, b[7:0]};
      `EX_LHU: extend = {16'd0, b[15:0]};
      default: extend = b;
    endcase
  endfunction

  state_t      state_r, next_state_s;
  logic [1:0]  cnt_r, next_cnt_s;
  logic [31:0] buf_r, next_buf_s;
  logic        load_s, store_s, mem_op_s;

  assign load_s   = is_load(aluop_i);
  assign store_s  = is_store(aluop_i);
  assign mem_op_s = load_s | store_s;

  // State, byte counter and load buffer registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= 2'd0;
      buf_r   <= 32'd0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= next_cnt_s;
      buf_r   <= next_buf_s;
    end
  end

  // Next-state logic; load bytes arrive one cycle after their address.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    next_buf_s   = buf_r;
    case (state_r)
      IDLE: begin
        if (mem_op_s && mem_gnt) begin
          next_state_s = ACCESS;
          next_cnt_s   = 2'd0;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS: begin
        if (load_s && (cnt_r != 2'd0)) begin
          next_buf_s[{cnt_r - 2'd1, 3'b000} +: 8] = mem_din;
        end else begin
          next_buf_s = buf_r;
        end
        if (cnt_r == last_idx(aluop_i)) begin
          next_state_s = store_s ? DONE : WAIT;
        end else begin
          next_cnt_s = cnt_r + 2'd1;
        end
      end
      WAIT: begin
        next_buf_s[{last_idx(aluop_i), 3'b000} +: 8] = mem_din;
        next_state_s = DONE;
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Output decode; everything is held low while reset is asserted.
  always_comb begin
    mem_req     = 1'b0;
    mem_a       = 32'd0;
    mem_dout    = 8'd0;
    mem_wr      = 1'b0;
    rd_addr_o   = 5'd0;
    rd_enable_o = 1'b0;
    wb_data_o   = 32'd0;
    stall_req   = 1'b0;
    if (rst) begin
      rd_addr_o = rd_addr_i;
      case (state_r)
        IDLE: begin
          if (mem_op_s) begin
            stall_req = 1'b1;
            mem_req   = 1'b1;
          end else begin
            wb_data_o   = data_i;
            rd_enable_o = rd_enable_i;
          end
        end
        ACCESS: begin
          stall_req = 1'b1;
          mem_req   = 1'b1;
          mem_a     = mem_addr_i + {30'd0, cnt_r};
          if (store_s) begin
            mem_wr   = 1'b1;
            mem_dout = data_i[{cnt_r, 3'b000} +: 8];
          end else begin
            mem_wr   = 1'b0;
          end
        end
        WAIT: begin
          stall_req = 1'b1;
          mem_req   = 1'b1;
        end
        DONE: begin
          if (load_s) begin
            wb_data_o   = extend(aluop_i, buf_r);
            rd_enable_o = rd_enable_i;
          end else begin
            wb_data_o   = 32'd0;
            rd_enable_o = 1'b0;
          end
        end
        default: begin
          stall_req = 1'b0;
        end
      endcase
    end else begin
      rd_addr_o = 5'd0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a byte-wide RAM model (read data one
// cycle after the address) and immediate-assertion checks.
`ifndef MEM_STAGE_DEFINES
`define MEM_STAGE_DEFINES
`define OpCodeLen 8
`define MEM_NOP   8'h00
`define EX_LB     8'h20
`define EX_LH     8'h21
`define EX_LW     8'h22
`define EX_LBU    8'h23
`define EX_LHU    8'h24
`define EX_SB     8'h25
`define EX_SH     8'h26
`define EX_SW     8'h27
`endif

module tb_mem_stage;
  logic                  clk = 1'b0;
  logic                  rst;
  logic [`OpCodeLen-1:0] aluop_i;
  logic [4:0]            rd_addr_i;
  logic                  rd_enable_i;
  logic [31:0]           data_i;
  logic [31:0]           mem_addr_i;
  logic                  mem_gnt;
  logic [7:0]            mem_din;
  logic                  mem_req;
  logic [31:0]           mem_a;
  logic [7:0]            mem_dout;
  logic                  mem_wr;
  logic [4:0]            rd_addr_o;
  logic                  rd_enable_o;
  logic [31:0]           wb_data_o;
  logic                  stall_req;

  logic [7:0] ram [0:1023];
  int         wr_count = 0;
  int         total = 0;
  int         bad = 0;

  mem_stage dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .rd_addr_i(rd_addr_i),
    .rd_enable_i(rd_enable_i), .data_i(data_i), .mem_addr_i(mem_addr_i),
    .mem_gnt(mem_gnt), .mem_din(mem_din), .mem_req(mem_req), .mem_a(mem_a),
    .mem_dout(mem_dout), .mem_wr(mem_wr), .rd_addr_o(rd_addr_o),
    .rd_enable_o(rd_enable_o), .wb_data_o(wb_data_o), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, read data valid the cycle after the address.
  always @(posedge clk) begin
    if (mem_req && mem_wr) begin
      ram[mem_a[9:0]] <= mem_dout;
      wr_count <= wr_count + 1;
    end
    mem_din <= ram[mem_a[9:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one memory op from IDLE to DONE, checking the byte sequence,
  // stall length and write-back; leaves inputs applied after DONE.
  task automatic mem_op(input string tag, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input int gnt_delay, input int nbytes,
                        input bit store, input int exp_stall, input logic [31:0] exp_wb,
                        input logic exp_rden);
    int stalls = 0;
    int acc = 0;
    int cyc = 0;
    bit done = 1'b0;
    logic [31:0] dv;
    aluop_i = op; mem_addr_i = addr; data_i = data;
    rd_addr_i = 5'd9; rd_enable_i = 1'b1;
    mem_gnt = (gnt_delay == 0);
    dv = data;
    while (!done && cyc < 30) begin
      @(negedge clk);
      if (!stall_req) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (cyc < gnt_delay) begin
          check({tag, "_wait_a"}, mem_a, 32'd0);
          check({tag, "_wait_wr"}, {31'd0, mem_wr}, 32'd0);
        end
        if (mem_wr || mem_a != 32'd0) begin
          check({tag, "_a"}, mem_a, addr + acc);
          check({tag, "_wr"}, {31'd0, mem_wr}, {31'd0, store});
          if (store) check({tag, "_dout"}, {24'd0, mem_dout}, {24'd0, dv[8*acc +: 8]});
          check({tag, "_rden_stall"}, {31'd0, rd_enable_o}, 32'd0);
          acc++;
        end
        tick();
        cyc++;
        if (cyc == gnt_delay) mem_gnt = 1'b1;
      end
    end
    check({tag, "_timeout"}, {31'd0, done}, 32'd1);
    check({tag, "_stall"}, stalls, exp_stall);
    check({tag, "_bytes"}, acc, nbytes);
    check({tag, "_wb"}, wb_data_o, exp_wb);
    check({tag, "_rden"}, {31'd0, rd_enable_o}, {31'd0, exp_rden});
    check({tag, "_req_done"}, {31'd0, mem_req}, 32'd0);
    tick();
    mem_gnt = 1'b0;
  endtask

  initial begin
    int wr_base;
    for (int i = 0; i < 1024; i++) ram[i] = 8'd0;
    ram[10'h100] = 8'h78; ram[10'h101] = 8'h56;
    ram[10'h102] = 8'h34; ram[10'h103] = 8'h12;
    ram[10'h020] = 8'h80; ram[10'h021] = 8'hFF;

    rst = 1'b0; aluop_i = `EX_LW; rd_addr_i = 5'd3; rd_enable_i = 1'b1;
    data_i = 32'hFFFF_FFFF; mem_addr_i = 32'h100; mem_gnt = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("rst_stall", {31'd0, stall_req}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_wb", wb_data_o, 32'd0);
    check("rst_rden", {31'd0, rd_enable_o}, 32'd0);
    check("rst_rdaddr", {27'd0, rd_addr_o}, 32'd0);
    tick();
    rst = 1'b1; mem_gnt = 1'b0;
    aluop_i = `MEM_NOP; data_i = 32'h1234; rd_addr_i = 5'd5; rd_enable_i = 1'b1;
    @(negedge clk);
    check("add_wb", wb_data_o, 32'h1234);
    check("add_rd", {27'd0, rd_addr_o}, 32'd5);
    check("add_rden", {31'd0, rd_enable_o}, 32'd1);
    check("add_stall", {31'd0, stall_req}, 32'd0);
    check("add_req", {31'd0, mem_req}, 32'd0);
    tick();

    mem_op("lw", `EX_LW, 32'h100, 32'h0, 0, 4, 1'b0, 6, 32'h1234_5678, 1'b1);
    mem_op("lb", `EX_LB, 32'h20, 32'h0, 0, 1, 1'b0, 3, 32'hFFFF_FF80, 1'b1);
    mem_op("lbu", `EX_LBU, 32'h20, 32'h0, 0, 1, 1'b0, 3, 32'h0000_0080, 1'b1);
    mem_op("lh", `EX_LH, 32'h20, 32'h0, 0, 2, 1'b0, 4, 32'hFFFF_FF80, 1'b1);
    mem_op("lhu", `EX_LHU, 32'h20, 32'h0, 0, 2, 1'b0, 4, 32'h0000_FF80, 1'b1);

    wr_base = wr_count;
    mem_op("sh", `EX_SH, 32'h41, 32'hDEAD_BEEF, 0, 2, 1'b1, 3, 32'd0, 1'b0);
    check("sh_count", wr_count - wr_base, 2);
    check("sh_m41", {24'd0, ram[10'h041]}, 32'hEF);
    check("sh_m42", {24'd0, ram[10'h042]}, 32'hBE);
    check("sh_m43", {24'd0, ram[10'h043]}, 32'h00);

    mem_op("sb", `EX_SB, 32'h30, 32'h1122_3344, 0, 1, 1'b1, 2, 32'd0, 1'b0);
    check("sb_m30", {24'd0, ram[10'h030]}, 32'h44);
    check("sb_m31", {24'd0, ram[10'h031]}, 32'h00);

    mem_op("lw_gnt", `EX_LW, 32'h100, 32'h0, 3, 4, 1'b0, 9, 32'h1234_5678, 1'b1);

    // Reset in the middle of a word store, right after the second byte.
    wr_base = wr_count;
    aluop_i = `EX_SW; mem_addr_i = 32'h60; data_i = 32'hA1B2_C3D4; mem_gnt = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("rsw_stall", {31'd0, stall_req}, 32'd0);
    check("rsw_req", {31'd0, mem_req}, 32'd0);
    check("rsw_wr", {31'd0, mem_wr}, 32'd0);
    check("rsw_a", mem_a, 32'd0);
    check("rsw_rden", {31'd0, rd_enable_o}, 32'd0);
    tick();
    rst = 1'b1; mem_gnt = 1'b0;
    aluop_i = `MEM_NOP; data_i = 32'h55; rd_addr_i = 5'd7; rd_enable_i = 1'b1;
    @(negedge clk);
    check("rsw_add_wb", wb_data_o, 32'h55);
    check("rsw_add_rden", {31'd0, rd_enable_o}, 32'd1);
    check("rsw_add_stall", {31'd0, stall_req}, 32'd0);
    check("rsw_count", wr_count - wr_base, 2);
    check("rsw_m60", {24'd0, ram[10'h060]}, 32'hD4);
    check("rsw_m61", {24'd0, ram[10'h061]}, 32'hC3);
    check("rsw_m62", {24'd0, ram[10'h062]}, 32'h00);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
